pwm_ramp_ctrl: RTL and testbench

PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

---
 rtl/pwm_ctrl_pkg.sv | 16 +
 rtl/pwm_ramp_step.sv | 39 +++
 rtl/pwm_ramp_ctrl.sv | 116 +++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_ctrl_pkg.sv
// rtl/pwm_ctrl_pkg.sv - shared state encoding and limits for the PWM ramp controller
package pwm_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_RAMP_DOWN = 2'd2,
        ST_HOLD      = 2'd3
    } ramp_state_e;

    localparam int unsigned DUTY_MAX_DEFAULT = 100;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/pwm_ramp_step.sv
// rtl/pwm_ramp_step.sv - saturating one-step duty arithmetic toward a target
module pwm_ramp_step
    import pwm_ctrl_pkg::*;
#(
    parameter int DUTY_W = 7
) (
    input  logic [DUTY_W-1:0] duty,
    input  logic [DUTY_W-1:0] tgt,
    input  logic [3:0]        stp,
    input  logic              dir,
    output logic [DUTY_W-1:0] next_duty
);

    logic [DUTY_W:0]   up_sum;
    logic [DUTY_W-1:0] down_gap;

    // Sum carries one extra bit so it cannot wrap; the gap is only used when duty is above tgt.
    assign up_sum   = {1'b0, duty} + (DUTY_W+1)'(stp);
    assign down_gap = duty - tgt;

    // Clamp the step so the result lands exactly on tgt rather than overshooting it.
    always_comb begin
        next_duty = duty;
        if (dir == DIR_UP) begin
            if (up_sum >= {1'b0, tgt}) begin
                next_duty = tgt;
            end else begin
                next_duty = up_sum[DUTY_W-1:0];
            end
        end else begin
            if ((duty <= tgt) || (down_gap <= DUTY_W'(stp))) begin
                next_duty = tgt;
            end else begin
                next_duty = duty - DUTY_W'(stp);
            end
        end
    end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// rtl/pwm_ramp_ctrl.sv - ramps the PWM duty toward a target in steps aligned to PWM periods
module pwm_ramp_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int DUTY_W   = 7,
    parameter int DUTY_MAX = DUTY_MAX_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [DUTY_W-1:0] target_duty,
    input  logic [3:0]        step,
    input  logic [7:0]        interval,
    input  logic              period_tick,
    output logic [DUTY_W-1:0] duty_out,
    output logic              busy,
    output logic              done,
    output logic [1:0]        state_out
);

    localparam logic [DUTY_W-1:0] DUTY_MAX_V = DUTY_W'(DUTY_MAX);

    ramp_state_e       state_q, state_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [DUTY_W-1:0] tgt_q, tgt_d;
    logic [3:0]        stp_q, stp_d;
    logic [7:0]        ivl_q, ivl_d;
    logic [7:0]        ivl_cnt_q, ivl_cnt_d;
    logic              done_q, done_d;

    logic              ramping;
    logic [DUTY_W-1:0] start_tgt;
    logic [3:0]        start_stp;
    logic [DUTY_W-1:0] next_duty;

    assign ramping   = (state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DOWN);
    assign start_tgt = (target_duty > DUTY_MAX_V) ? DUTY_MAX_V : target_duty;
    assign start_stp = (step == 4'd0) ? 4'd1 : step;

    pwm_ramp_step #(
        .DUTY_W (DUTY_W)
    ) u_step (
        .duty      (duty_q),
        .tgt       (tgt_q),
        .stp       (stp_q),
        .dir       ((state_q == ST_RAMP_DOWN) ? DIR_DOWN : DIR_UP),
        .next_duty (next_duty)
    );

    // Next-state: abort beats start, start beats a tick, and ticks only matter while ramping.
    always_comb begin
        state_d   = state_q;
        duty_d    = duty_q;
        tgt_d     = tgt_q;
        stp_d     = stp_q;
        ivl_d     = ivl_q;
        ivl_cnt_d = ivl_cnt_q;
        done_d    = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
            duty_d  = '0;
        end else if (start && !ramping) begin
            tgt_d     = start_tgt;
            stp_d     = start_stp;
            ivl_d     = interval;
            ivl_cnt_d = interval;
            if (start_tgt > duty_q) begin
                state_d = ST_RAMP_UP;
            end else if (start_tgt < duty_q) begin
                state_d = ST_RAMP_DOWN;
            end else begin
                state_d = ST_HOLD;
                done_d  = 1'b1;
            end
        end else if (ramping && period_tick) begin
            if (ivl_cnt_q != 8'd0) begin
                ivl_cnt_d = ivl_cnt_q - 8'd1;
            end else begin
                ivl_cnt_d = ivl_q;
                duty_d    = next_duty;
                if (next_duty == tgt_q) begin
                    state_d = ST_HOLD;
                    done_d  = 1'b1;
                end
            end
        end
    end

    // State and ramp context registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            duty_q    <= '0;
            tgt_q     <= '0;
            stp_q     <= 4'd1;
            ivl_q     <= 8'd0;
            ivl_cnt_q <= 8'd0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            duty_q    <= duty_d;
            tgt_q     <= tgt_d;
            stp_q     <= stp_d;
            ivl_q     <= ivl_d;
            ivl_cnt_q <= ivl_cnt_d;
            done_q    <= done_d;
        end
    end

    assign duty_out  = duty_q;
    assign done      = done_q;
    assign busy      = ramping;
    assign state_out = state_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb/tb_pwm_ramp_ctrl.sv - self-checking bench for pwm_ramp_ctrl against a behavioural model
module tb_pwm_ramp_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [6:0] target_duty;
    logic [3:0] step;
    logic [7:0] interval;
    logic       period_tick;
    logic [6:0] duty_out;
    logic       busy;
    logic       done;
    logic [1:0] state_out;

    int checks   = 0;
    int failures = 0;

    // Reference model: state as 0 idle, 1 up, 2 down, 3 hold
    int m_state, m_duty, m_tgt, m_stp, m_ivl, m_cnt, m_done;

    pwm_ramp_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .target_duty (target_duty),
        .step        (step),
        .interval    (interval),
        .period_tick (period_tick),
        .duty_out    (duty_out),
        .busy        (busy),
        .done        (done),
        .state_out   (state_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rs, input bit st, input bit ab, input int td,
                              input int sp, input int iv, input bit tk);
        m_done = 0;
        if (!rs) begin
            m_state = 0; m_duty = 0; m_tgt = 0; m_stp = 1; m_ivl = 0; m_cnt = 0;
        end else if (ab) begin
            m_state = 0; m_duty = 0;
        end else if (st && (m_state == 0 || m_state == 3)) begin
            m_tgt = (td > 100) ? 100 : td;
            m_stp = (sp == 0) ? 1 : sp;
            m_ivl = iv;
            m_cnt = iv;
            if (m_tgt > m_duty) m_state = 1;
            else if (m_tgt < m_duty) m_state = 2;
            else begin m_state = 3; m_done = 1; end
        end else if ((m_state == 1 || m_state == 2) && tk) begin
            if (m_cnt != 0) begin
                m_cnt = m_cnt - 1;
            end else begin
                m_cnt = m_ivl;
                if (m_state == 1)
                    m_duty = (m_duty + m_stp > m_tgt) ? m_tgt : m_duty + m_stp;
                else
                    m_duty = (m_duty - m_tgt <= m_stp) ? m_tgt : m_duty - m_stp;
                if (m_duty == m_tgt) begin m_state = 3; m_done = 1; end
            end
        end
    endtask

    // One clock: drive inputs, advance model on the edge, compare every output 1 time unit later.
    task automatic cycle(input bit rs, input bit st, input bit ab, input int td,
                         input int sp, input int iv, input bit tk);
        rst_n = rs; start = st; abort = ab;
        target_duty = 7'(td); step = 4'(sp); interval = 8'(iv); period_tick = tk;
        @(posedge clk);
        model_edge(rs, st, ab, td, sp, iv, tk);
        #1;
        check("duty", int'(duty_out), m_duty);
        check("state", int'(state_out), m_state);
        check("busy", int'(busy), (m_state == 1 || m_state == 2) ? 1 : 0);
        check("done", int'(done), m_done);
        start = 1'b0; abort = 1'b0; period_tick = 1'b0; rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick_after(input int gap);
        idle(gap);
        cycle(1, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic start_ramp(input int td, input int sp, input int iv);
        cycle(1, 1, 0, td, sp, iv, 0);
    endtask

    initial begin
        int expv[3];
        int n;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; target_duty = '0;
        step = '0; interval = '0; period_tick = 1'b0;
        m_state = 0; m_duty = 0; m_tgt = 0; m_stp = 1; m_ivl = 0; m_cnt = 0; m_done = 0;

        // Reset state
        cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        check("rst_duty", int'(duty_out), 0);
        check("rst_state", int'(state_out), 0);
        check("rst_busy", int'(busy), 0);
        idle(2);

        // Ramp 0 -> 40 in steps of 10, ticks 256 clocks apart
        start_ramp(40, 10, 0);
        check("ru_state", int'(state_out), 1);
        for (int k = 1; k <= 4; k++) begin
            tick_after(255);
            check("ru_duty", int'(duty_out), 10 * k);
        end
        check("ru_done", int'(done), 1);
        check("ru_hold", int'(state_out), 3);
        idle(1);
        check("ru_done_pulse", int'(done), 0);

        // Ramp down 40 -> 5, step 15, step every 2nd tick
        start_ramp(5, 15, 1);
        check("rd_state", int'(state_out), 2);
        expv[0] = 25; expv[1] = 10; expv[2] = 5;
        for (int k = 0; k < 3; k++) begin
            tick_after(3);
            check("rd_hold_duty", int'(duty_out), (k == 0) ? 40 : expv[k-1]);
            tick_after(3);
            check("rd_duty", int'(duty_out), expv[k]);
        end
        check("rd_done", int'(done), 1);
        check("rd_hold", int'(state_out), 3);

        // Clamp target above DUTY_MAX
        start_ramp(120, 15, 0);
        n = 0;
        while (state_out != 2'd3 && n < 20) begin
            tick_after(2);
            n++;
        end
        check("clamp_duty", int'(duty_out), 100);
        check("clamp_state", int'(state_out), 3);

        // Abort mid-ramp at duty 30
        cycle(1, 0, 1, 0, 0, 0, 0);
        start_ramp(60, 10, 0);
        for (int k = 0; k < 3; k++) tick_after(1);
        check("ab_pre", int'(duty_out), 30);
        cycle(1, 0, 1, 0, 0, 0, 0);
        check("ab_duty", int'(duty_out), 0);
        check("ab_state", int'(state_out), 0);
        check("ab_done", int'(done), 0);
        cycle(1, 1, 1, 50, 5, 0, 0);
        check("abst_state", int'(state_out), 0);
        check("abst_duty", int'(duty_out), 0);

        // Start during RAMP_UP is ignored; start at current duty goes straight to HOLD
        start_ramp(50, 10, 0);
        tick_after(1);
        start_ramp(90, 1, 0);
        check("ign_state", int'(state_out), 1);
        for (int k = 0; k < 4; k++) tick_after(1);
        check("ign_duty", int'(duty_out), 50);
        check("ign_done", int'(done), 1);
        idle(1);
        start_ramp(50, 3, 0);
        check("eq_state", int'(state_out), 3);
        check("eq_done", int'(done), 1);

        // Start together with a tick in HOLD: accepted, no step
        cycle(1, 1, 0, 80, 10, 0, 1);
        check("sttk_duty", int'(duty_out), 50);
        check("sttk_state", int'(state_out), 1);
        tick_after(0);
        check("sttk_step", int'(duty_out), 60);

        // One-cycle reset mid-ramp
        cycle(0, 0, 0, 0, 0, 0, 0);
        check("mrst_duty", int'(duty_out), 0);
        check("mrst_state", int'(state_out), 0);
        check("mrst_busy", int'(busy), 0);
        tick_after(1);
        check("mrst_tick", int'(duty_out), 0);

        // Randomised traffic against the model
        for (int i = 0; i < 4000; i++) begin
            cycle(($urandom_range(0, 299) != 0),
                  ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 149) == 0),
                  int'($urandom_range(0, 127)),
                  int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
